multdiv_sequencer: RTL and testbench
====================================

// Module: multdiv_sequencer
// PURPOSE
//  Issue/hold stage in front of the iterative multiplier and divider; one op in flight.
//  Accepts an op from decode via valid/ready and holds both operands stable for the whole op.
//  Pulses ctrl_MULT/ctrl_DIV once, waits for data_resultRDY, captures result+exception.
//  Presents the captured result to writeback via valid/ready; drives busy as the pipeline stall.
// PARAMETERS
//  TIMEOUT  40  max cycles in WAIT before forced abort; must exceed the unit latency (32)
//  TAG_W    5   width of destination-register tag carried alongside the op
// PORTS
//  clock           in   1      rising-edge clock
//  reset_n         in   1      synchronous, active-low reset
//  in_valid        in   1      decode presents an op
//  in_ready        out  1      sequencer can accept (=1 only in IDLE)
//  in_op           in   1      0=multiply, 1=divide
//  in_a            in   32     operand A (dividend / multiplicand)
//  in_b            in   32     operand B (divisor / multiplier)
//  in_tag          in   TAG_W  destination tag, returned unchanged
//  data_operandA   out  32     held operand A to unit
//  data_operandB   out  32     held operand B to unit
//  ctrl_MULT       out  1      one-cycle start pulse to multiplier
//  ctrl_DIV        out  1      one-cycle start pulse to divider
//  unit_result     in   32     data_result from selected unit
//  unit_exception  in   1      data_exception from selected unit
//  unit_resultRDY  in   1      data_resultRDY from selected unit (free-running, periodic)
//  out_valid       out  1      result available
//  out_ready       in   1      writeback consumes result
//  out_result      out  32     captured result
//  out_exception   out  1      captured exception (or timeout abort)
//  out_tag         out  TAG_W  tag of the completed op
//  busy            out  1      =1 in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0 (in_ready=1 once reset_n=1), op/tag/operand regs cleared.
//  States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  IDLE: in_ready=1; on in_valid latch in_op/in_a/in_b/in_tag -> ISSUE.
//  ISSUE (1 cycle): ctrl_DIV=in_op, ctrl_MULT=~in_op; unit_resultRDY IGNORED (stale counter) -> WAIT.
//  WAIT: wait counter from 0; first cycle unit_resultRDY=1 -> capture result/exception -> DONE.
//   counter reaches TIMEOUT-1 without RDY -> out_result=0, out_exception=1 -> DONE.
//  DONE: out_valid=1, outputs stable until out_ready=1 -> IDLE (same edge clears out_valid).
//  in_valid in DONE is not accepted, even with out_ready=1 that cycle; accepted next cycle in IDLE.
//  data_operandA/B driven from latched regs in all states; change only on IDLE acceptance.
//  Latency with the 32-cycle divider: accept edge -> out_valid high 33 cycles later.
//  Periodic RDY pulses outside WAIT are ignored; unit needs no abort (ctrl pulses stay 0).
//  reset_n=0 mid-op: same-edge return to IDLE, result discarded, no ctrl pulse emitted.
//  ctrl_MULT and ctrl_DIV never high together; each high exactly one cycle per accepted op.
// CONFIGURATION
//  MULTDIV_DIV0_BYPASS_EN defined: divide with in_b==0 goes IDLE -> DONE directly,
//   out_result=0, out_exception=1, no ctrl_DIV pulse; out_valid 1 cycle after accept.
//  Undefined: divide-by-zero issues normally; exception taken from unit_exception at RDY.
// TESTING
//  div 100/7 -> out_result=14, out_exception=0, out_valid exactly 33 cycles after accept.
//  div -100/7 -> 0xFFFFFFF2; mult 6*-7 -> 0xFFFFFFD6; ctrl pulse one cycle, operands stable.
//  div 5/0 -> out_exception=1 (bypass: 1-cycle latency, no ctrl_DIV; else after unit RDY).
//  stub unit never raising RDY -> out_valid after TIMEOUT cycles in WAIT, result=0, exception=1.
//  RDY forced high during ISSUE -> ignored, result taken at true RDY; out_ready low 5 cycles
//   -> outputs held, in_ready=0, busy=1.
//  reset_n=0 for 1 cycle mid-WAIT -> IDLE, out_valid=0, no later output; new op completes OK.

Source files
------------

// File: rtl/multdiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_sequencer_if
// Description : Decode, unit and writeback signal bundle for multdiv_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface multdiv_sequencer_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic             in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      data_operandA;
    logic [31:0]      data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [31:0]      unit_result;
    logic             unit_exception;
    logic             unit_resultRDY;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic             out_exception;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag,
        input  unit_result, unit_exception, unit_resultRDY, out_ready,
        output in_ready, data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output out_valid, out_result, out_exception, out_tag, busy
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag,
        output unit_result, unit_exception, unit_resultRDY, out_ready,
        input  in_ready, data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  out_valid, out_result, out_exception, out_tag, busy
    );
endinterface
`default_nettype wire

// File: rtl/multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_sequencer
// Description : One-op-in-flight issue/hold stage for the iterative mul/div
//               units. Optional MULTDIV_DIV0_BYPASS_EN completes divide-by-zero
//               without starting the divider.
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_sequencer #(
    parameter int TIMEOUT = 40,
    parameter int TAG_W   = 5
) (
    input  wire logic           clock,
    input  wire logic           reset_n,
    multdiv_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int                 c_cnt_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_op;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [TAG_W-1:0]   r_tag;
    logic [31:0]        r_result;
    logic               r_exc;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_accept;
    logic               w_capture;
    logic               w_timeout;
`ifdef MULTDIV_DIV0_BYPASS_EN
    logic               w_bypass;
`endif

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
`ifdef MULTDIV_DIV0_BYPASS_EN
        w_bypass     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_ISSUE;
`ifdef MULTDIV_DIV0_BYPASS_EN
                    if (bus.in_op && (bus.in_b == 32'd0)) begin
                        w_bypass     = 1'b1;
                        w_next_state = S_DONE;
                    end
`endif
                end
            end
            // The unit's ready is periodic, so a pulse seen here belongs to a previous op.
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT: begin
                if (bus.unit_resultRDY) begin
                    w_capture    = 1'b1;
                    w_next_state = S_DONE;
                end else if (r_cnt == c_cnt_last) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_op     <= 1'b0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_tag    <= '0;
            r_result <= 32'd0;
            r_exc    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op  <= bus.in_op;
                r_a   <= bus.in_a;
                r_b   <= bus.in_b;
                r_tag <= bus.in_tag;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + c_cnt_one;
            end
            if (w_capture) begin
                r_result <= bus.unit_result;
                r_exc    <= bus.unit_exception;
            end else if (w_timeout) begin
                r_result <= 32'd0;
                r_exc    <= 1'b1;
            end
`ifdef MULTDIV_DIV0_BYPASS_EN
            else if (w_bypass) begin
                r_result <= 32'd0;
                r_exc    <= 1'b1;
            end
`endif
        end
    end

    // Gating with reset_n keeps every control output low while reset is held.
    assign bus.in_ready      = reset_n && (r_state == S_IDLE);
    assign bus.busy          = reset_n && (r_state != S_IDLE);
    assign bus.ctrl_MULT     = reset_n && (r_state == S_ISSUE) && !r_op;
    assign bus.ctrl_DIV      = reset_n && (r_state == S_ISSUE) && r_op;
    assign bus.out_valid     = reset_n && (r_state == S_DONE);
    assign bus.data_operandA = r_a;
    assign bus.data_operandB = r_b;
    assign bus.out_result    = r_result;
    assign bus.out_exception = r_exc;
    assign bus.out_tag       = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multdiv_sequencer
// Description : Self-checking bench for multdiv_sequencer with a 32-cycle unit stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_sequencer;

    localparam int TIMEOUT     = 40;
    localparam int TAG_W       = 5;
    localparam int UNIT_CYCLES = 32;

    logic clock;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    multdiv_sequencer_if #(.TAG_W(TAG_W)) bus ();

    multdiv_sequencer #(.TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Unit stub: start pulse cycle counts as cycle 1, ready in cycle 32.
    int          ucnt = 0;
    logic        uop = 1'b0;
    logic [31:0] ua = 32'd0;
    logic [31:0] ub = 32'd0;
    logic        force_rdy = 1'b0;
    logic        unit_dead = 1'b0;
    logic        real_rdy;
    logic [31:0] calc_res;
    logic        calc_exc;

    always @(posedge clock) begin
        if (bus.ctrl_MULT || bus.ctrl_DIV) begin
            ucnt <= 1;
            uop  <= bus.ctrl_DIV;
            ua   <= bus.data_operandA;
            ub   <= bus.data_operandB;
        end else if (ucnt == UNIT_CYCLES - 1) begin
            ucnt <= 0;
        end else if (ucnt != 0) begin
            ucnt <= ucnt + 1;
        end
    end

    always_comb begin
        calc_exc = 1'b0;
        calc_res = 32'd0;
        if (!uop) begin
            calc_res = 32'($signed(ua) * $signed(ub));
        end else if (ub == 32'd0) begin
            calc_exc = 1'b1;
        end else begin
            calc_res = 32'($signed(ua) / $signed(ub));
        end
    end

    assign real_rdy           = (ucnt == UNIT_CYCLES - 1) && !unit_dead;
    assign bus.unit_resultRDY = real_rdy || force_rdy;
    assign bus.unit_result    = real_rdy ? calc_res : 32'hDEAD_BEEF;
    assign bus.unit_exception = real_rdy ? calc_exc : 1'b1;

    int n_mult = 0;
    int n_div  = 0;
    int n_both = 0;
    always @(negedge clock) begin
        if (bus.ctrl_MULT) n_mult <= n_mult + 1;
        if (bus.ctrl_DIV)  n_div  <= n_div + 1;
        if (bus.ctrl_MULT && bus.ctrl_DIV) n_both <= n_both + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] tag);
        int g = 0;
        while (!bus.in_ready && g < 100) begin
            tick();
            g++;
        end
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Cycle count where the accept cycle is 0.
    task automatic wait_done(input logic [31:0] a, input logic [31:0] b,
                             output int n, output bit stable);
        n      = 1;
        stable = 1'b1;
        while (!bus.out_valid && n < 200) begin
            if (bus.data_operandA !== a || bus.data_operandB !== b) stable = 1'b0;
            tick();
            n++;
        end
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    typedef struct {
        logic             op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
        logic             exc;
        int               lat;
        int               mp;
        int               dp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int  n;
        bit  st;
        int  m0, d0;
        bit  held;

        vecs[0] = '{1'b1, 32'd100,        32'd7,          5'd3,  32'd14,         1'b0, 33, 0, 1};
        vecs[1] = '{1'b1, 32'hFFFF_FF9C,  32'd7,          5'd17, 32'hFFFF_FFF2,  1'b0, 33, 0, 1};
        vecs[2] = '{1'b0, 32'd6,          32'hFFFF_FFF9,  5'd31, 32'hFFFF_FFD6,  1'b0, 33, 1, 0};
        vecs[3] = '{1'b0, 32'h0001_0000,  32'h0001_0000,  5'd1,  32'd0,          1'b0, 33, 1, 0};
        vecs[4] = '{1'b0, 32'd12345,      32'd3,          5'd22, 32'h0000_90AB,  1'b0, 33, 1, 0};
`ifdef MULTDIV_DIV0_BYPASS_EN
        vecs[5] = '{1'b1, 32'd5,          32'd0,          5'd9,  32'd0,          1'b1, 1,  0, 0};
`else
        vecs[5] = '{1'b1, 32'd5,          32'd0,          5'd9,  32'd0,          1'b1, 33, 0, 1};
`endif

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 1'b0;
        bus.in_a      = 32'd0;
        bus.in_b      = 32'd0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        check("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("rst_busy",         32'(bus.busy),     32'd0);
        check("rst_out_valid",    32'(bus.out_valid), 32'd0);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready",   32'(bus.in_ready),   32'd1);
        check("rst_out_result", bus.out_result,      32'd0);
        check("rst_out_tag",    32'(bus.out_tag),    32'd0);
        check("rst_operandA",   bus.data_operandA,   32'd0);

        for (int i = 0; i < 6; i++) begin
            m0 = n_mult;
            d0 = n_div;
            start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
            wait_done(vecs[i].a, vecs[i].b, n, st);
            check($sformatf("v%0d_latency", i),   32'(n),                 32'(vecs[i].lat));
            check($sformatf("v%0d_result", i),    bus.out_result,         vecs[i].res);
            check($sformatf("v%0d_exception", i), 32'(bus.out_exception), 32'(vecs[i].exc));
            check($sformatf("v%0d_tag", i),       32'(bus.out_tag),       32'(vecs[i].tag));
            check($sformatf("v%0d_mult_pulses", i), 32'(n_mult - m0),     32'(vecs[i].mp));
            check($sformatf("v%0d_div_pulses", i),  32'(n_div - d0),      32'(vecs[i].dp));
            check($sformatf("v%0d_operands", i),  32'(st),                32'd1);
            finish_op();
            check($sformatf("v%0d_released", i),  32'(bus.out_valid),     32'd0);
        end

        // Stale ready during ISSUE, then writeback stalls for 5 cycles.
        start_op(1'b1, 32'd100, 32'd7, 5'd12);
        force_rdy = 1'b1;
        tick();
        force_rdy = 1'b0;
        wait_done(32'd100, 32'd7, n, st);
        n = n + 1;
        check("issue_rdy_latency", 32'(n), 32'd33);
        check("issue_rdy_result",  bus.out_result, 32'd14);
        check("issue_rdy_exc",     32'(bus.out_exception), 32'd0);
        held = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (!bus.out_valid || bus.in_ready || !bus.busy ||
                bus.out_result !== 32'd14 || bus.out_tag !== 5'd12) held = 1'b0;
        end
        check("hold_5_cycles", 32'(held), 32'd1);

        // in_valid during DONE with out_ready must not be accepted.
        bus.in_op     = 1'b0;
        bus.in_a      = 32'd2;
        bus.in_b      = 32'd3;
        bus.in_tag    = 5'd9;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("done_no_accept_busy",  32'(bus.busy),      32'd0);
        check("done_no_accept_ready", 32'(bus.in_ready),  32'd1);
        check("done_no_accept_valid", 32'(bus.out_valid), 32'd0);
        tick();
        bus.in_valid = 1'b0;
        wait_done(32'd2, 32'd3, n, st);
        check("next_op_latency", 32'(n), 32'd33);
        check("next_op_result",  bus.out_result, 32'd6);
        check("next_op_tag",     32'(bus.out_tag), 32'd9);
        finish_op();

        // Unit never answers: abort after TIMEOUT cycles in WAIT.
        unit_dead = 1'b1;
        start_op(1'b0, 32'd3, 32'd3, 5'd4);
        wait_done(32'd3, 32'd3, n, st);
        check("timeout_latency", 32'(n), 32'(TIMEOUT + 2));
        check("timeout_result",  bus.out_result, 32'd0);
        check("timeout_exc",     32'(bus.out_exception), 32'd1);
        finish_op();
        unit_dead = 1'b0;

        // Reset mid-WAIT: op is dropped, the late unit ready is ignored.
        start_op(1'b1, 32'd100, 32'd7, 5'd7);
        repeat (5) tick();
        check("midop_busy", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        check("midrst_busy",      32'(bus.busy),      32'd0);
        m0   = n_mult;
        d0   = n_div;
        held = 1'b1;
        for (int k = 0; k < TIMEOUT + 5; k++) begin
            tick();
            if (bus.out_valid || bus.busy) held = 1'b0;
        end
        check("midrst_quiet",  32'(held), 32'd1);
        check("midrst_no_ctrl", 32'((n_mult - m0) + (n_div - d0)), 32'd0);
        start_op(1'b0, 32'd6, 32'hFFFF_FFF9, 5'd2);
        wait_done(32'd6, 32'hFFFF_FFF9, n, st);
        check("post_rst_latency", 32'(n), 32'd33);
        check("post_rst_result",  bus.out_result, 32'hFFFF_FFD6);
        finish_op();

        check("ctrl_exclusive", 32'(n_both), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
